// File: rtl/mycounter_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mycounter_param                                               |
// | Purpose  : Parametrised up/down counter with synchronous clear/load,     |
// |            wrap or saturate at the bounds, terminal-count decode and a   |
// |            registered overflow pulse. Optional en-cycle prescaler.       |
// | Macro    : MYCOUNTER_PRESCALE_EN - when defined, a count step is taken   |
// |            only on every PRESCALE_DIV-th enabled cycle.                  |
// | Ports    : CLK      in  1      rising-edge clock                         |
// |            RST      in  1      asynchronous active-high reset            |
// |            en       in  1      count enable                              |
// |            up_dn    in  1      1: count up, 0: count down                |
// |            clr      in  1      synchronous clear to RESET_VAL            |
// |            load     in  1      synchronous load of load_val (clamped)    |
// |            load_val in  WIDTH  load value                                |
// |            out      out WIDTH  registered count                          |
// |            tc       out 1      terminal count (combinational decode)     |
// |            ovf      out 1      registered one-cycle bound pulse          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mycounter_param #(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] MAX          = {WIDTH{1'b1}},
  parameter int               SATURATE     = 0,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter int               PRESCALE_DIV = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  // Elaboration-time parameter sanity checks.
  if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
    $error("mycounter_param: WIDTH must be 1..32");
  end
  if (RESET_VAL > MAX) begin : g_bad_reset_val
    $error("mycounter_param: RESET_VAL must not exceed MAX");
  end
  if (PRESCALE_DIV < 1) begin : g_bad_prescale
    $error("mycounter_param: PRESCALE_DIV must be >= 1");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             step_qual;

`ifdef MYCOUNTER_PRESCALE_EN
  localparam int               c_PS_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE_DIV - 1);

  logic [c_PS_W-1:0] ps_q, ps_d;
`endif

  always_comb begin
    out_d     = out_q;
    ovf_d     = 1'b0;
    step_qual = 1'b0;
`ifdef MYCOUNTER_PRESCALE_EN
    ps_d      = ps_q;
`endif

    if (clr) begin
      out_d = RESET_VAL;
`ifdef MYCOUNTER_PRESCALE_EN
      ps_d  = '0;
`endif
    end else if (load) begin
      // Out-of-range loads are clamped so out never exceeds MAX.
      out_d = (load_val > MAX) ? MAX : load_val;
`ifdef MYCOUNTER_PRESCALE_EN
      ps_d  = '0;
`endif
    end else if (en) begin
`ifdef MYCOUNTER_PRESCALE_EN
      // Prescaler only advances on enabled cycles; the step fires on its last count.
      if (ps_q == c_PS_LAST) begin
        ps_d      = '0;
        step_qual = 1'b1;
      end else begin
        ps_d      = ps_q + 1'b1;
      end
`else
      step_qual = 1'b1;
`endif
    end

    if (step_qual) begin
      if (up_dn) begin
        if (out_q == MAX) begin
          ovf_d = 1'b1;
          out_d = (SATURATE != 0) ? MAX : '0;
        end else begin
          out_d = out_q + 1'b1;
        end
      end else begin
        if (out_q == '0) begin
          ovf_d = 1'b1;
          out_d = (SATURATE != 0) ? '0 : MAX;
        end else begin
          out_d = out_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_q <= RESET_VAL;
      ovf_q <= 1'b0;
`ifdef MYCOUNTER_PRESCALE_EN
      ps_q  <= '0;
`endif
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
`ifdef MYCOUNTER_PRESCALE_EN
      ps_q  <= ps_d;
`endif
    end
  end

  assign out = out_q;
  assign ovf = ovf_q;
  // Terminal count is the bound in the currently requested direction.
  assign tc  = up_dn ? (out_q == MAX) : (out_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_mycounter_param.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mycounter_param                                            |
// | Purpose  : Directed self-checking bench for mycounter_param. Three       |
// |            instances share stimulus: default (4-bit wrap), MAX=9         |
// |            saturating, MAX=9 wrapping.                                   |
// | Macro    : MYCOUNTER_PRESCALE_EN selects the prescaler scenario set.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mycounter_param;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] out_def, out_sat, out_wrp;
  logic       tc_def,  tc_sat,  tc_wrp;
  logic       ovf_def, ovf_sat, ovf_wrp;

  int checks;
  int errors;

  mycounter_param u_def (
    .CLK(clk), .RST(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .out(out_def), .tc(tc_def), .ovf(ovf_def)
  );

  mycounter_param #(.WIDTH(4), .MAX(4'd9), .SATURATE(1)) u_sat (
    .CLK(clk), .RST(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .out(out_sat), .tc(tc_sat), .ovf(ovf_sat)
  );

  mycounter_param #(.WIDTH(4), .MAX(4'd9), .SATURATE(0)) u_wrp (
    .CLK(clk), .RST(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .out(out_wrp), .tc(tc_wrp), .ovf(ovf_wrp)
  );

  // 20 us period
  initial clk = 1'b0;
  always #10000 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    tick(); tick();
    checks++;
    if (out_def !== 4'd0 || ovf_def !== 1'b0 || tc_def !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: out=%0d ovf=%b tc=%b expected out=0 ovf=0 tc=0", out_def, ovf_def, tc_def);
    end
    rst = 1'b0;
`ifndef MYCOUNTER_PRESCALE_EN
    en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (out_def !== 4'd7) begin
      errors++;
      $display("FAIL reset_precount: out=%0d expected 7", out_def);
    end
    // Assert reset mid-cycle, well away from any clock edge.
    en = 1'b0;
    #100;
    rst = 1'b1;
    #1;
    checks++;
    if (out_def !== 4'd0 || ovf_def !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out=%0d ovf=%b expected out=0 ovf=0", out_def, ovf_def);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_def !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: out=%0d expected 0", i, out_def);
      end
    end
    en = 1'b0;
    rst = 1'b0;
    tick();
`endif
  endtask

`ifndef MYCOUNTER_PRESCALE_EN
  task automatic test_up_wrap();
    logic [3:0] exp_out;
    logic       exp_ovf;
    exp_out = 4'd0;
    exp_ovf = 1'b0;
    up_dn = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_def !== exp_out || tc_def !== (exp_out == 4'd15) || ovf_def !== exp_ovf) begin
        errors++;
        $display("FAIL up_wrap[%0d]: out=%0d tc=%b ovf=%b expected out=%0d tc=%b ovf=%b",
                 i, out_def, tc_def, ovf_def, exp_out, (exp_out == 4'd15), exp_ovf);
      end
      exp_ovf = (exp_out == 4'd15);
      exp_out = exp_out + 4'd1;
      tick();
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_down_bounds();
    logic [3:0] sat_out [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       sat_ovf [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       sat_tc  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] wrp_out [5] = '{4'd1, 4'd0, 4'd9, 4'd8, 4'd7};
    logic       wrp_ovf [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0;
    checks++;
    if (out_sat !== 4'd2 || ovf_sat !== 1'b0) begin
      errors++;
      $display("FAIL down_load: out=%0d ovf=%b expected out=2 ovf=0", out_sat, ovf_sat);
    end
    up_dn = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_sat !== sat_out[i] || ovf_sat !== sat_ovf[i] || tc_sat !== sat_tc[i]) begin
        errors++;
        $display("FAIL down_sat[%0d]: out=%0d ovf=%b tc=%b expected out=%0d ovf=%b tc=%b",
                 i, out_sat, ovf_sat, tc_sat, sat_out[i], sat_ovf[i], sat_tc[i]);
      end
      checks++;
      if (out_wrp !== wrp_out[i] || ovf_wrp !== wrp_ovf[i]) begin
        errors++;
        $display("FAIL down_wrap[%0d]: out=%0d ovf=%b expected out=%0d ovf=%b",
                 i, out_wrp, ovf_wrp, wrp_out[i], wrp_ovf[i]);
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_direction();
    up_dn = 1'b1; en = 1'b0; load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (out_wrp !== 4'd8 || tc_wrp !== 1'b0) begin
      errors++;
      $display("FAIL dir_up8: out=%0d tc=%b expected out=8 tc=0", out_wrp, tc_wrp);
    end
    tick();
    checks++;
    if (out_wrp !== 4'd9 || tc_wrp !== 1'b1) begin
      errors++;
      $display("FAIL dir_up9: out=%0d tc=%b expected out=9 tc=1", out_wrp, tc_wrp);
    end
    up_dn = 1'b0;
    #1;
    checks++;
    if (tc_wrp !== 1'b0) begin
      errors++;
      $display("FAIL dir_tc_flip: tc=%b expected 0", tc_wrp);
    end
    tick();
    checks++;
    if (out_wrp !== 4'd8 || tc_wrp !== 1'b0 || ovf_wrp !== 1'b0) begin
      errors++;
      $display("FAIL dir_dn8: out=%0d tc=%b ovf=%b expected out=8 tc=0 ovf=0", out_wrp, tc_wrp, ovf_wrp);
    end
    tick();
    checks++;
    if (out_wrp !== 4'd7) begin
      errors++;
      $display("FAIL dir_dn7: out=%0d expected 7", out_wrp);
    end
    en = 1'b0;
    tick();
  endtask
`endif

  task automatic test_priority();
    up_dn = 1'b1; en = 1'b1; clr = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    checks++;
    if (out_sat !== 4'd0 || out_def !== 4'd0 || ovf_sat !== 1'b0) begin
      errors++;
      $display("FAIL prio_clr: out_sat=%0d out_def=%0d ovf=%b expected 0 0 0", out_sat, out_def, ovf_sat);
    end
    clr = 1'b0; load = 1'b1; load_val = 4'd12; en = 1'b0;
    tick();
    checks++;
    if (out_sat !== 4'd9 || out_def !== 4'd12) begin
      errors++;
      $display("FAIL prio_load_clamp: out_sat=%0d out_def=%0d expected 9 12", out_sat, out_def);
    end
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_sat !== 4'd9 || ovf_sat !== 1'b0) begin
        errors++;
        $display("FAIL prio_hold[%0d]: out=%0d ovf=%b expected out=9 ovf=0", i, out_sat, ovf_sat);
      end
    end
  endtask

`ifdef MYCOUNTER_PRESCALE_EN
  task automatic test_prescale();
    en = 1'b0; clr = 1'b1; load = 1'b0; up_dn = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 9 || i == 10 || i == 20 || i == 30) begin
        checks++;
        if (out_def !== 4'(i / 10)) begin
          errors++;
          $display("FAIL prescale_cnt[%0d]: out=%0d expected %0d", i, out_def, i / 10);
        end
      end
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_def !== 4'd3 || ovf_def !== 1'b0) begin
        errors++;
        $display("FAIL prescale_hold[%0d]: out=%0d ovf=%b expected out=3 ovf=0", i, out_def, ovf_def);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
`ifdef MYCOUNTER_PRESCALE_EN
    test_prescale();
    test_priority();
`else
    test_up_wrap();
    test_down_bounds();
    test_priority();
    test_direction();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
